// File: rtl/nand_dq_tx.sv
// NAND DQ/DQS write-burst transmitter: frames an even-length byte burst with a
// DQS preamble and postamble, presenting one byte per DQS edge.
module nand_dq_tx #(
  parameter int unsigned PRE_CYC  = 2,
  parameter int unsigned POST_CYC = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  input  logic [13:0] req_len,
  output logic        req_ready,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  output logic        dqs_out,
  output logic        dqs_oe,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  state_dbg
);

  // Handshakes: a request is taken on a rising edge where req_valid && req_ready;
  // a byte is taken on a rising edge where wr_valid && wr_ready. wr_ready
  // depends combinationally on wr_valid, so the producer may not wait on it.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] PRE_LOAD  = 4'(PRE_CYC - 1);
  localparam logic [3:0] POST_LOAD = 4'(POST_CYC - 1);

  state_t      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [3:0]  ph_q, ph_d;
  logic [7:0]  dq_q, dq_d;
  logic        dqs_q, dqs_d;
  logic        err_q, err_d;
  logic [13:0] len_even;
  logic        consume;

  assign len_even = req_len & 14'h3ffe;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    dq_d    = dq_q;
    dqs_d   = dqs_q;
    err_d   = err_q;
    consume = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cnt_d = len_even;
          if (len_even == 14'd0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            ph_d    = PRE_LOAD;
            state_d = S_PRE;
          end
        end
      end

      S_PRE: begin
        if (ph_q == 4'd0) begin
          state_d = S_DATA;
        end else begin
          ph_d = ph_q - 4'd1;
        end
      end

      S_DATA: begin
        // The last byte is still on the bus for one cycle after the count
        // hits zero, so POST starts only once it has been presented.
        if (cnt_q == 14'd0) begin
          ph_d    = POST_LOAD;
          state_d = S_POST;
        end else if (wr_valid) begin
          consume = 1'b1;
          dq_d    = wr_data;
          dqs_d   = ~dqs_q;
          cnt_d   = cnt_q - 14'd1;
        end
      end

      S_POST: begin
        dqs_d = 1'b0;
        if (ph_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          ph_d = ph_q - 4'd1;
        end
      end

      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 14'd0;
      ph_q    <= 4'd0;
      dq_q    <= 8'h00;
      dqs_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      dq_q    <= dq_d;
      dqs_q   <= dqs_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    wr_ready  = consume;
    dq_out    = dq_q;
    dq_oe     = (state_q == S_DATA);
    dqs_out   = dqs_q;
    dqs_oe    = (state_q == S_PRE) || (state_q == S_DATA) || (state_q == S_POST);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    err       = (state_q == S_DONE) && err_q;
    state_dbg = state_q;
  end

  a_wr_ready_in_data : assert property (@(posedge CLK) disable iff (RST)
    wr_ready |-> (state_q == S_DATA));

  a_done_single : assert property (@(posedge CLK) disable iff (RST)
    done |=> !done);

endmodule
